// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the ram_bytemask block.
//   ram_state_t : controller state (RAM_CLEAR zero-fills, RAM_IDLE serves accesses)
//   RAM_BYTE_W  : width of one byte lane
package ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_IDLE} ram_state_t;

  localparam int RAM_BYTE_W = 8;

endpackage

// File: rtl/ram_bytemask_if.sv
// ram_bytemask_if: access bus of the byte-masked RAM.
//   i_clr   : request zero-fill of the whole array (taken only while o_ready=1)
//   i_we    : write enable
//   i_wmask : per-byte write qualifier, bit k covers i_wdata[8k+7:8k]
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : registered read data
//   o_ready : 1 = array usable, 0 = clear in progress
// master modport drives the request side, slave modport is the RAM.
interface ram_bytemask_if
  import ram_pkg::*;
#(
  parameter int ADDR_LEN   = 7,
  parameter int DATA_BYTES = 1
) ();

  logic                               i_clr;
  logic                               i_we;
  logic [DATA_BYTES-1:0]              i_wmask;
  logic [ADDR_LEN-1:0]                i_addr;
  logic [RAM_BYTE_W*DATA_BYTES-1:0]   i_wdata;
  logic [RAM_BYTE_W*DATA_BYTES-1:0]   o_rdata;
  logic                               o_ready;

  modport master (
    output i_clr, i_we, i_wmask, i_addr, i_wdata,
    input  o_rdata, o_ready
  );

  modport slave (
    input  i_clr, i_we, i_wmask, i_addr, i_wdata,
    output o_rdata, o_ready
  );

endinterface

// File: rtl/ram_lane.sv
// ram_lane: one 8-bit wide, 2**ADDR_LEN deep synchronous RAM lane.
//   clk, rst : clock; asynchronous active-high reset of the read register only
//   we       : write enable for this lane
//   rd_en    : 1 = load read register from the array, 0 = load zero
//   addr     : word address (shared by read and write)
//   wdata    : lane write data
//   rdata    : registered lane read data
// Build option RAM_WRITE_FIRST_EN: a same-cycle write to this lane is
// forwarded to rdata; otherwise rdata returns the pre-write contents.
module ram_lane
  import ram_pkg::*;
#(
  parameter int ADDR_LEN = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  rd_en,
  input  logic [ADDR_LEN-1:0]   addr,
  input  logic [RAM_BYTE_W-1:0] wdata,
  output logic [RAM_BYTE_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_LEN;

  logic [RAM_BYTE_W-1:0] mem [DEPTH];
  logic [RAM_BYTE_W-1:0] rdata_p1;

  // array write: no reset, contents are established by the clear engine
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // stage p1: registered read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1 <= '0;
    end else if (!rd_en) begin
      rdata_p1 <= '0;
`ifdef RAM_WRITE_FIRST_EN
    end else if (we) begin
      rdata_p1 <= wdata;
`endif
    end else begin
      rdata_p1 <= mem[addr];
    end
  end

  assign rdata = rdata_p1;

endmodule

// File: rtl/ram_bytemask.sv
// ram_bytemask: parametrised single-port RAM with per-byte write mask and a
// hardware clear engine that zero-fills the array after reset or on request.
//   clk  : clock, all logic on rising edge
//   rst  : asynchronous active-high reset (restarts the clear at address 0)
//   bus  : ram_bytemask_if.slave (i_clr, i_we, i_wmask, i_addr, i_wdata,
//          o_rdata, o_ready)
// Parameters: ADDR_LEN (depth 2**ADDR_LEN words), DATA_BYTES (bytes/word).
// Build option RAM_WRITE_FIRST_EN selects write-first read-during-write
// (masked bytes return new data); default is read-first.
module ram_bytemask
  import ram_pkg::*;
#(
  parameter int ADDR_LEN   = 7,
  parameter int DATA_BYTES = 1
) (
  input  logic            clk,
  input  logic            rst,
  ram_bytemask_if.slave   bus
);

  ram_state_t            state;
  ram_state_t            state_next;
  logic [ADDR_LEN-1:0]   clr_addr;
  logic [ADDR_LEN-1:0]   clr_addr_next;
  logic                  clearing;
  logic [ADDR_LEN-1:0]   lane_addr;

  // controller state and clear counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RAM_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    case (state)
      RAM_CLEAR: begin
        // counter wraps to 0 on the last word, leaving it ready for the next clear
        clr_addr_next = clr_addr + ADDR_LEN'(1);
        if (&clr_addr) begin
          state_next = RAM_IDLE;
        end
      end
      RAM_IDLE: begin
        if (bus.i_clr) begin
          state_next = RAM_CLEAR;
        end
      end
    endcase
  end

  assign clearing    = (state == RAM_CLEAR);
  assign bus.o_ready = (state == RAM_IDLE);
  assign lane_addr   = clearing ? clr_addr : bus.i_addr;

  // one lane per byte; the clear engine owns every lane while clearing
  for (genvar k = 0; k < DATA_BYTES; k++) begin : g_lane
    logic                  lane_we;
    logic [RAM_BYTE_W-1:0] lane_wdata;

    assign lane_we    = clearing | (bus.i_we & bus.i_wmask[k]);
    assign lane_wdata = clearing ? '0 : bus.i_wdata[k*RAM_BYTE_W +: RAM_BYTE_W];

    ram_lane #(
      .ADDR_LEN (ADDR_LEN)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (lane_we),
      .rd_en (!clearing),
      .addr  (lane_addr),
      .wdata (lane_wdata),
      .rdata (bus.o_rdata[k*RAM_BYTE_W +: RAM_BYTE_W])
    );
  end

endmodule

// File: tb/tb_ram_bytemask.sv
// tb_ram_bytemask: self-checking bench for ram_bytemask (ADDR_LEN=7, DATA_BYTES=4).
// Expected read data are pushed to a scoreboard queue as each access is
// driven and popped when the registered read data appears.
module tb_ram_bytemask;
  import ram_pkg::*;

  localparam int AL = 7;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ram_bytemask_if #(.ADDR_LEN(AL), .DATA_BYTES(DB)) bus ();

  ram_bytemask #(.ADDR_LEN(AL), .DATA_BYTES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rf;
    logic [31:0] exp_wf;
  } vec_t;

  localparam int NV = 14;
  vec_t        vt [NV];
  logic [31:0] sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // drive one access before the edge, return 1 time unit after it
  task automatic drive(input logic clr, input logic we, input logic [3:0] mask,
                       input logic [6:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.i_clr   = clr;
    bus.i_we    = we;
    bus.i_wmask = mask;
    bus.i_addr  = addr;
    bus.i_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_read(input string nm, input logic [6:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    drive(1'b0, 1'b0, 4'h0, addr, 32'h0);
    sb_q.push_back(exp);
    e = sb_q.pop_front();
    check(nm, bus.o_rdata, e);
  endtask

  // count edges until o_ready rises (bounded) with inputs held as they are
  task automatic count_clear(input string nm);
    int   rise = 0;
    logic nz   = 1'b0;
    for (int e = 1; e <= 200 && rise == 0; e++) begin
      @(posedge clk);
      #1;
      if (bus.o_ready === 1'b1) rise = e;
      else if (bus.o_rdata !== 32'h0) nz = 1'b1;
    end
    check({nm, "_edges"}, 32'(rise), 32'd128);
    check({nm, "_rdata0"}, 32'(nz), 32'd0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 4'hF, 7'd5,   32'hAABBCCDD, 32'h00000000, 32'hAABBCCDD};
    vt[1]  = '{1'b1, 4'h5, 7'd5,   32'h11223344, 32'hAABBCCDD, 32'hAA22CC44};
    vt[2]  = '{1'b0, 4'h0, 7'd5,   32'h00000000, 32'hAA22CC44, 32'hAA22CC44};
    vt[3]  = '{1'b1, 4'hF, 7'd9,   32'h00000012, 32'h00000000, 32'h00000012};
    vt[4]  = '{1'b1, 4'hF, 7'd9,   32'h00000034, 32'h00000012, 32'h00000034};
    vt[5]  = '{1'b0, 4'h0, 7'd9,   32'h00000000, 32'h00000034, 32'h00000034};
    vt[6]  = '{1'b1, 4'h0, 7'd5,   32'hFFFFFFFF, 32'hAA22CC44, 32'hAA22CC44};
    vt[7]  = '{1'b0, 4'h0, 7'd5,   32'h00000000, 32'hAA22CC44, 32'hAA22CC44};
    vt[8]  = '{1'b1, 4'h1, 7'd127, 32'h0000005A, 32'h00000000, 32'h0000005A};
    vt[9]  = '{1'b0, 4'h0, 7'd127, 32'h00000000, 32'h0000005A, 32'h0000005A};
    vt[10] = '{1'b1, 4'h8, 7'd6,   32'h77000000, 32'h00000000, 32'h77000000};
    vt[11] = '{1'b1, 4'h2, 7'd6,   32'h1234EE78, 32'h77000000, 32'h7700EE00};
    vt[12] = '{1'b0, 4'h0, 7'd6,   32'h00000000, 32'h7700EE00, 32'h7700EE00};
    vt[13] = '{1'b0, 4'h0, 7'd0,   32'h00000000, 32'h00000000, 32'h00000000};

    rst         = 1'b1;
    bus.i_clr   = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_wmask = '0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_rdata", bus.o_rdata, 32'h0);

    // release reset with a write to addr 3 held during the clear
    @(negedge clk);
    rst         = 1'b0;
    bus.i_we    = 1'b1;
    bus.i_wmask = 4'hF;
    bus.i_addr  = 7'd3;
    bus.i_wdata = 32'hFFFFFFFF;
    count_clear("rst_clear");

    for (int a = 0; a < 128; a++) begin
      sb_read($sformatf("zero_a%0d", a), 7'(a), 32'h0);
    end

    // table of masked writes / reads
    for (int i = 0; i < NV; i++) begin
      logic [31:0] e;
      drive(1'b0, vt[i].we, vt[i].mask, vt[i].addr, vt[i].wdata);
`ifdef RAM_WRITE_FIRST_EN
      sb_q.push_back(vt[i].exp_wf);
`else
      sb_q.push_back(vt[i].exp_rf);
`endif
      e = sb_q.pop_front();
      check($sformatf("vec%0d", i), bus.o_rdata, e);
    end
    check("idle_ready", 32'(bus.o_ready), 32'd1);

    // clear request: the accepting edge still reads addr 127
    drive(1'b1, 1'b0, 4'h0, 7'd127, 32'h0);
    check("clr_accept_rdata", bus.o_rdata, 32'h0000005A);
    check("clr_accept_ready", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    bus.i_clr = 1'b0;
    count_clear("req_clear");
    sb_read("clr_a127", 7'd127, 32'h0);
    sb_read("clr_a5", 7'd5, 32'h0);
    sb_read("clr_a9", 7'd9, 32'h0);

    // asynchronous reset while o_rdata is non-zero
    drive(1'b0, 1'b1, 4'hF, 7'd2, 32'hCAFEF00D);
    sb_read("pre_rst_a2", 7'd2, 32'hCAFEF00D);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rdata", bus.o_rdata, 32'h0);
    check("async_rst_ready", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // reset again 50 edges into the clear
    repeat (50) @(posedge clk);
    #1;
    check("mid_clear_ready", 32'(bus.o_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.o_ready), 32'd0);
    check("mid_rst_rdata", bus.o_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    count_clear("mid_rst_clear");
    sb_read("post_rst_a2", 7'd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
